// File: rtl/shiftreg_sipo_rx.sv
// shiftreg_sipo_rx: LSB-first serial-in/parallel-out receiver with word
// framing, a one-word holding register and a valid/ready output handshake.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset_L    asynchronous active-low reset
//   clear      synchronous flush of partial word, held word and overrun
//   ser_in     serial data bit, sampled when enable=1
//   enable     bit strobe, one bit shifted in per strobed clock
//   data_out   held word, bit 0 = first bit received
//   valid      data_out holds an unconsumed word
//   ready      consumer takes data_out when valid & ready
//   overrun    sticky flag, a completed word was dropped
//   bit_count  bits received toward the current word
module shiftreg_sipo_rx #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 clear,
  input  logic                 ser_in,
  input  logic                 enable,
  input  logic                 ready,
  output logic [W-1:0]         data_out,
  output logic                 valid,
  output logic                 overrun,
  output logic [$clog2(W)-1:0] bit_count
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic [W-1:0]  cand;
  logic          done;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= EMPTY;
      sh_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    cand    = {ser_in, sh_q[W-1:1]};
    done    = enable && (cnt_q == LAST);
    state_d = state_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (clear) begin
      state_d = EMPTY;
      sh_d    = '0;
      dout_d  = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      if (enable) begin
        sh_d  = cand;
        cnt_d = done ? '0 : cnt_q + CW'(1);
      end
      unique case (state_q)
        EMPTY: begin
          if (done) begin
            state_d = FULL;
            dout_d  = cand;
          end
        end
        FULL: begin
          // A word landing while full replaces the held one only
          // if the consumer takes the old one in the same cycle.
          if (done) begin
            if (ready) dout_d = cand;
            else       ovr_d  = 1'b1;
          end else if (ready) begin
            state_d = EMPTY;
          end
        end
      endcase
    end
  end

  assign data_out  = dout_q;
  assign valid     = (state_q == FULL);
  assign overrun   = ovr_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_shiftreg_sipo_rx.sv
// tb_shiftreg_sipo_rx: directed bench for shiftreg_sipo_rx with a
// queue-based reference model and per-cycle output comparison.
module tb_shiftreg_sipo_rx;

  localparam int W = 8;

  logic                 clk = 1'b0;
  logic                 reset_L = 1'b1;
  logic                 clear = 1'b0;
  logic                 ser_in = 1'b0;
  logic                 enable = 1'b0;
  logic                 ready = 1'b0;
  logic [W-1:0]         data_out;
  logic                 valid;
  logic                 overrun;
  logic [$clog2(W)-1:0] bit_count;

  int checks = 0;
  int failures = 0;

  bit           mq[$];
  logic [W-1:0] m_data = '0;
  bit           m_valid = 1'b0;
  bit           m_ovr = 1'b0;

  shiftreg_sipo_rx #(.W(W)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .clear     (clear),
    .ser_in    (ser_in),
    .enable    (enable),
    .ready     (ready),
    .data_out  (data_out),
    .valid     (valid),
    .overrun   (overrun),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  always @(negedge reset_L) m_reset();

  always @(posedge clk) begin : model
    logic [W-1:0] w;
    bit           got;
    got = 1'b0;
    w   = '0;
    if (!reset_L || clear) begin
      m_reset();
    end else begin
      if (enable) begin
        mq.push_back(ser_in);
        if (mq.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = mq[i];
          mq.delete();
          got = 1'b1;
        end
      end
      if (got) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = w;
        end else if (ready) begin
          m_data = w;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_valid", 32'(valid), 32'(m_valid));
    chk("cmp_data", 32'(data_out), 32'(m_data));
    chk("cmp_overrun", 32'(overrun), 32'(m_ovr));
    chk("cmp_bit_count", 32'(bit_count), 32'(mq.size()));
  end

  task automatic cyc(input logic en, input logic b,
                     input logic rdy, input logic clr);
    @(posedge clk);
    #2;
    enable = en;
    ser_in = b;
    ready  = rdy;
    clear  = clr;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap,
                           input logic rdy_last);
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, w[i], (i == W - 1) ? rdy_last : 1'b0, 1'b0);
      if (i < W - 1)
        for (int g = 0; g < gap; g++) idle();
    end
    idle();
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_L = 1'b0;
    repeat (3) @(posedge clk);
    look();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_cnt", 32'(bit_count), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(posedge clk);
    #2 reset_L = 1'b1;

    send_word(8'hB0, 0, 1'b0);
    look();
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_data", 32'(data_out), 32'hB0);
    chk("t1_cnt", 32'(bit_count), 32'd0);
    chk("t1_ovr", 32'(overrun), 32'd0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    look();
    chk("t2_consumed", 32'(valid), 32'd0);
    chk("t2_stale", 32'(data_out), 32'hB0);
    send_word(8'h5A, 3, 1'b0);
    look();
    chk("t2_valid", 32'(valid), 32'd1);
    chk("t2_data", 32'(data_out), 32'h5A);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hB0, 0, 1'b0);
    send_word(8'h3C, 0, 1'b0);
    look();
    chk("t3_ovr", 32'(overrun), 32'd1);
    chk("t3_data", 32'(data_out), 32'hB0);
    chk("t3_valid", 32'(valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    look();
    chk("t3_valid_after", 32'(valid), 32'd0);
    chk("t3_ovr_sticky", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    look();
    chk("t3_ovr_cleared", 32'(overrun), 32'd0);

    send_word(8'hB0, 0, 1'b0);
    send_word(8'hC3, 0, 1'b1);
    look();
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_data", 32'(data_out), 32'hC3);
    chk("t4_ovr", 32'(overrun), 32'd0);

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i & 1), 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #3 reset_L = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid), 32'd0);
    chk("t5_rst_data", 32'(data_out), 32'd0);
    chk("t5_rst_cnt", 32'(bit_count), 32'd0);
    chk("t5_rst_ovr", 32'(overrun), 32'd0);
    #2 reset_L = 1'b1;
    send_word(8'hA5, 0, 1'b0);
    look();
    chk("t5_data", 32'(data_out), 32'hA5);
    chk("t5_valid", 32'(valid), 32'd1);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    look();
    chk("t6_cnt", 32'(bit_count), 32'd0);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_ovr", 32'(overrun), 32'd0);
    chk("t6_data", 32'(data_out), 32'd0);
    send_word(8'hFF, 0, 1'b0);
    look();
    chk("t6_ff", 32'(data_out), 32'hFF);
    chk("t6_ff_valid", 32'(valid), 32'd1);

    repeat (2) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
